// File: rtl/multi_spi_tx.sv
// MultiSPI transmitter: serialises a REGSIZE-bit frame as MSB-first nibbles on O,
// framing each nibble with S, holding each for DIV cycles and honouring a far-end hold.
module multi_spi_tx #(
  parameter int REGSIZE = 32,
  parameter int DIV     = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [REGSIZE-1:0] load_data,
  input  logic               hold,
  output logic [3:0]         O,
  output logic [1:0]         S,
  output logic               busy,
  output logic               done
);

  localparam int NIB = REGSIZE / 4;
  localparam int CW  = $clog2(NIB + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(NIB);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [7:0]    PRE_LOAD = 8'(DIV - 1);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t             state, state_n;
  logic [REGSIZE-1:0] sh, sh_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [7:0]         pre, pre_n;
  logic               done_q, done_n;

  // Handshake: a frame transfers on a rising edge where load_valid and load_ready
  // are both high; load_ready is high exactly in IDLE (including the done cycle),
  // so offers made while busy are simply not taken.
  always_comb begin
    state_n = state;
    sh_n    = sh;
    cnt_n   = cnt;
    pre_n   = pre;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (load_valid) begin
          sh_n    = load_data;
          cnt_n   = CNT_LOAD;
          pre_n   = PRE_LOAD;
          state_n = SEND;
        end
      end
      SEND: begin
        if (!hold) begin
          if (pre != 8'd0) begin
            pre_n = pre - 8'd1;
          end else begin
            sh_n  = sh << 4;
            cnt_n = cnt - CNT_ONE;
            pre_n = PRE_LOAD;
            // Last nibble finished: the following IDLE cycle carries the done pulse
            if (cnt == CNT_ONE) begin
              state_n = IDLE;
              done_n  = 1'b1;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sh     <= '0;
      cnt    <= '0;
      pre    <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      sh     <= sh_n;
      cnt    <= cnt_n;
      pre    <= pre_n;
      done_q <= done_n;
    end
  end

  assign load_ready = (state == IDLE);
  assign busy       = (state == SEND);
  assign done       = done_q;
  assign O          = busy ? sh[REGSIZE-1 -: 4] : 4'h0;
  assign S          = busy ? ((cnt == CNT_ONE) ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_multi_spi_tx.sv
// Bench for multi_spi_tx: two instances (DIV=1 and DIV=3) share one stimulus stream;
// each has a frame-level reference model whose expected nibbles live in a queue.
module tb_multi_spi_tx;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load_valid = 1'b0;
  logic [W-1:0] load_data = '0;
  logic         hold = 1'b0;
  bit           chk_en = 1'b0;

  logic       load_ready_w [2];
  logic [3:0] o_w          [2];
  logic [1:0] s_w          [2];
  logic       busy_w       [2];
  logic       done_w       [2];

  int n_checks = 0;
  int n_pass   = 0;

  // clock / reset
  always #5 clk = ~clk;

  multi_spi_tx #(.REGSIZE(W), .DIV(1)) dut_d1 (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready_w[0]),
    .load_data(load_data), .hold(hold), .O(o_w[0]), .S(s_w[0]),
    .busy(busy_w[0]), .done(done_w[0])
  );

  multi_spi_tx #(.REGSIZE(W), .DIV(3)) dut_d3 (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready_w[1]),
    .load_data(load_data), .hold(hold), .O(o_w[1]), .S(s_w[1]),
    .busy(busy_w[1]), .done(done_w[1])
  );

  // Scoreboard/monitor per instance: expected nibbles are queued when a frame is
  // accepted; each cycle the visible outputs are compared to the queue head.
  for (genvar g = 0; g < 2; g++) begin : mon
    localparam int MD = (g == 0) ? 1 : 3;
    logic [3:0] exp_q[$];
    int  m_left = 0;
    bit  m_busy = 1'b0;
    bit  m_done = 1'b0;

    always @(negedge clk) begin
      logic [8:0] got, exp;
      got = {load_ready_w[g], busy_w[g], done_w[g], s_w[g], o_w[g]};
      if (m_busy)
        exp = {1'b0, 1'b1, 1'b0, (exp_q.size() == 1) ? 2'b10 : 2'b01, exp_q[0]};
      else
        exp = {1'b1, 1'b0, m_done, 2'b00, 4'h0};
      if (chk_en) begin
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL outputs_div%0d t=%0t got {ready,busy,done,S,O}=%03h expected=%03h",
                      MD, $time, got, exp);
      end
      // advance the model to what the next rising edge should produce
      if (rst) begin
        m_busy = 1'b0;
        m_done = 1'b0;
        exp_q.delete();
      end else if (m_busy) begin
        m_done = 1'b0;
        if (!hold) begin
          m_left--;
          if (m_left == 0) begin
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) begin
              m_busy = 1'b0;
              m_done = 1'b1;
            end else begin
              m_left = MD;
            end
          end
        end
      end else begin
        m_done = 1'b0;
        if (load_valid) begin
          for (int i = 0; i < W / 4; i++) exp_q.push_back(load_data[W-1-4*i -: 4]);
          m_left = MD;
          m_busy = 1'b1;
        end
      end
    end
  end

  // driver tasks
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input logic [W-1:0] d);
    load_valid = 1'b1;
    load_data  = d;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic check_idle(input string name);
    logic [8:0] got;
    for (int g = 0; g < 2; g++) begin
      got = {load_ready_w[g], busy_w[g], done_w[g], s_w[g], o_w[g]};
      n_checks++;
      if (got === {1'b1, 1'b0, 1'b0, 2'b00, 4'h0}) n_pass++;
      else $display("FAIL %s inst%0d t=%0t got {ready,busy,done,S,O}=%03h expected=100",
                    name, g, $time, got);
    end
  endtask

  task automatic wait_done(input int g, input int max_cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      tick();
      if (done_w[g] === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen) n_pass++;
    else $display("FAIL wait_done inst%0d t=%0t: no done pulse within %0d cycles",
                  g, $time, max_cycles);
  endtask

  initial begin
    rst = 1'b1;
    tick(2);
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("reset_state");
    tick(2);

    // plain frames
    load(32'h12345678);
    wait_done(0, 12);
    tick(24);
    load(32'hA5C3F00F);
    wait_done(1, 40);
    tick(4);

    // hold for two cycles while the DIV=1 instance shows nibble 3
    load(32'h12345678);
    tick(2);
    hold = 1'b1;
    tick(2);
    hold = 1'b0;
    tick(30);

    // offers during SEND are ignored; an offer in the done cycle is taken
    load(32'hDEADBEEF);
    load_valid = 1'b1;
    load_data  = 32'h00000000;
    tick(8);
    load_data  = 32'h0BADF00D;
    tick();
    load_valid = 1'b0;
    tick(40);

    // reset while the DIV=1 instance shows nibble 5, then restart
    load(32'h12345678);
    tick(4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("midframe_reset");
    tick(2);
    load(32'h12345678);
    tick(30);

    // randomized traffic with occasional hold and reset
    for (int i = 0; i < 600; i++) begin
      load_valid = ($urandom_range(0, 2) != 0);
      load_data  = $urandom();
      hold       = ($urandom_range(0, 3) == 0);
      rst        = ($urandom_range(0, 149) == 0);
      tick();
    end
    load_valid = 1'b0;
    hold       = 1'b0;
    rst        = 1'b0;
    tick(40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
